// File: rtl/rede_pkg.sv
// Shared constants and dispatcher state encoding for the rede core array.
// The multicore input dispatcher and the output collector both import this package.
package rede_pkg;

    localparam int N_CORES  = 26;
    localparam int DATA_W   = 31;
    localparam int REQ_W    = 4;
    localparam int REQ_NONE = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GUARD = 2'd2
    } disp_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first set request at or after ptr, wrapping from N-1 back to 0.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    int unsigned pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = 32'(ptr) + i;
            if (pos >= 32'(N)) begin
                pos = pos - 32'(N);
            end
            if (!any && req[pos[PW-1:0]]) begin
                any = 1'b1;
                idx = pos[PW-1:0];
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/multicore_in_dispatch.sv
// Serves per-core input requests from one tagged sample stream: round-robin
// among matching cores, one-cycle one-hot grant, then a guard window.
module multicore_in_dispatch #(
    parameter int N_CORES   = 26,
    parameter int DATA_W    = 31,
    parameter int REQ_W     = 4,
    parameter int GUARD_CYC = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [DATA_W-1:0]  src_data,
    input  logic [REQ_W-1:0]          src_port,
    input  logic                      src_valid,
    output logic                      src_ready,
    input  logic [N_CORES*REQ_W-1:0]  req_in_flat,
    output logic signed [DATA_W-1:0]  io_in,
    output logic [REQ_W-1:0]          in_port,
    output logic [N_CORES-1:0]        in_grant
);

    import rede_pkg::*;

    localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int CW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
    localparam logic [PW-1:0] PTR_LAST = PW'(N_CORES - 1);

    disp_state_t          state;
    logic [N_CORES-1:0]   match;
    logic [N_CORES-1:0]   mask;
    logic [N_CORES-1:0]   arb_grant;
    logic [PW-1:0]        arb_idx;
    logic                 arb_any;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        winner;
    logic [CW-1:0]        cnt;
    logic [REQ_W-1:0]     req_k;

    always_comb begin
        match = '0;
        req_k = '0;
        for (int unsigned k = 0; k < N_CORES; k++) begin
            req_k    = req_in_flat[k*REQ_W +: REQ_W];
            match[k] = (req_k != REQ_W'(REQ_NONE)) && (req_k == src_port) && !mask[k];
        end
    end

    rr_arbiter #(
        .N  (N_CORES),
        .PW (PW)
    ) u_arb (
        .req   (match),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign src_ready = !rst && (state == IDLE) && src_valid && arb_any;

    // io_in/in_port double as the sample latch: loaded on transfer, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            mask     <= '0;
            cnt      <= '0;
            winner   <= '0;
            io_in    <= '0;
            in_port  <= '0;
            in_grant <= '0;
        end else begin
            in_grant <= '0;
            case (state)
                IDLE: begin
                    if (src_ready) begin
                        io_in    <= src_data;
                        in_port  <= src_port;
                        winner   <= arb_idx;
                        in_grant <= arb_grant;
                        rr_ptr   <= (arb_idx == PTR_LAST) ? '0 : arb_idx + 1'b1;
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (GUARD_CYC == 0) begin
                        state <= IDLE;
                    end else begin
                        mask[winner] <= 1'b1;
                        cnt          <= '0;
                        state        <= GUARD;
                    end
                end
                GUARD: begin
                    if (cnt == CNT_LAST) begin
                        mask  <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicore_in_dispatch.sv
// Directed bench for multicore_in_dispatch at default parameters (26 cores, guard 2).
module tb_multicore_in_dispatch;

    import rede_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [30:0]  src_data;
    logic [3:0]          src_port;
    logic                src_valid;
    logic                src_ready;
    logic [26*4-1:0]     req_in_flat;
    logic signed [30:0]  io_in;
    logic [3:0]          in_port;
    logic [25:0]         in_grant;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    multicore_in_dispatch #(
        .N_CORES   (26),
        .DATA_W    (31),
        .REQ_W     (4),
        .GUARD_CYC (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_data    (src_data),
        .src_port    (src_port),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .req_in_flat (req_in_flat),
        .io_in       (io_in),
        .in_port     (in_port),
        .in_grant    (in_grant)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a sample, wait (bounded) for acceptance, then check the DRIVE cycle.
    task automatic xfer(input string tag, input int core, input logic signed [30:0] d,
                        input logic [3:0] tag_port, output int waited);
        src_data  = d;
        src_port  = tag_port;
        src_valid = 1'b1;
        waited    = 0;
        #1;
        while (!src_ready && waited < 20) begin
            tick();
            waited++;
        end
        chk({tag, "_ready"}, 64'(src_ready), 64'd1);
        tick();
        src_valid = 1'b0;
        chk({tag, "_grant"}, 64'(in_grant), 64'd1 << core);
        chk({tag, "_io_in"}, 64'(io_in), 64'(d));
        chk({tag, "_port"}, 64'(in_port), 64'(tag_port));
    endtask

    initial begin
        int w;
        int cyc;
        logic bad;

        rst         = 1'b1;
        src_data    = '0;
        src_port    = '0;
        src_valid   = 1'b0;
        req_in_flat = '0;

        // Ready must stay low during reset even with a matching request.
        req_in_flat[5*4 +: 4] = 4'd3;
        src_port  = 4'd3;
        src_valid = 1'b1;
        tick();
        tick();
        chk("ready_in_rst", 64'(src_ready), 64'd0);
        src_valid   = 1'b0;
        req_in_flat = '0;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_io_in", 64'(io_in), 64'd0);
        chk("rst_port", 64'(in_port), 64'd0);
        chk("rst_grant", 64'(in_grant), 64'd0);
        chk("rst_ready", 64'(src_ready), 64'd0);

        // Round robin from rr_ptr=0 among cores 0, 1, 25.
        req_in_flat[0*4 +: 4]  = 4'd2;
        req_in_flat[1*4 +: 4]  = 4'd2;
        req_in_flat[25*4 +: 4] = 4'd2;
        xfer("rr0", 0, 31'sd100, 4'd2, w);
        chk("rr0_wait", 64'(w), 64'd0);
        xfer("rr1", 1, 31'sd200, 4'd2, w);
        chk("rr1_wait", 64'(w), 64'd3);
        xfer("rr2", 25, 31'sd300, 4'd2, w);
        chk("rr2_wait", 64'(w), 64'd3);
        xfer("rr3", 0, -31'sd400, 4'd2, w);
        chk("rr3_wait", 64'(w), 64'd3);
        req_in_flat = '0;
        tick();
        tick();
        tick();

        // Single request: core 5, code 3, sample -7.
        req_in_flat[5*4 +: 4] = 4'd3;
        xfer("single", 5, -31'sd7, 4'd3, w);
        tick();
        chk("single_t2_grant", 64'(in_grant), 64'd0);
        chk("single_t2_hold", 64'(io_in), 64'(-7));
        tick();
        chk("single_t3_grant", 64'(in_grant), 64'd0);
        tick();
        src_valid = 1'b1;
        #1;
        chk("single_t4_idle", 64'(src_ready), 64'd1);
        src_valid = 1'b0;
        #1;
        chk("single_idle_hold", 64'(in_port), 64'd3);
        req_in_flat = '0;

        // Tag mismatch stalls the source.
        req_in_flat[4*4 +: 4] = 4'd1;
        src_port  = 4'd2;
        src_data  = 31'sd55;
        src_valid = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (src_ready !== 1'b0 || in_grant !== '0) bad = 1'b1;
        end
        chk("mismatch_stall", 64'(bad), 64'd0);
        req_in_flat[9*4 +: 4] = 4'd2;
        xfer("mismatch_c9", 9, 31'sd55, 4'd2, w);
        chk("mismatch_c9_wait", 64'(w), 64'd0);
        req_in_flat = '0;
        tick();
        tick();
        tick();

        // Stale request held through GUARD by the only requester.
        req_in_flat[7*4 +: 4] = 4'd6;
        src_port  = 4'd6;
        src_data  = 31'sd77;
        src_valid = 1'b1;
        #1;
        chk("stale_ready", 64'(src_ready), 64'd1);
        tick();
        chk("stale_first", 64'(in_grant), 64'd1 << 7);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (in_grant == '0 && cyc < 20);
        chk("stale_gap", 64'(cyc), 64'd4);
        chk("stale_second", 64'(in_grant), 64'd1 << 7);
        src_valid   = 1'b0;
        req_in_flat = '0;
        tick();
        tick();
        tick();

        // Reset asserted in the DRIVE cycle.
        req_in_flat[2*4 +: 4] = 4'd5;
        xfer("rstmid", 2, 31'sd1234, 4'd5, w);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_grant", 64'(in_grant), 64'd0);
        chk("rstmid_io_in", 64'(io_in), 64'd0);
        chk("rstmid_port", 64'(in_port), 64'd0);
        chk("rstmid_state", 64'(dut.state == IDLE), 64'd1);
        chk("rstmid_ptr", 64'(dut.rr_ptr), 64'd0);
        tick();
        chk("rstmid_nogrant", 64'(in_grant), 64'd0);
        xfer("rstmid_again", 2, -31'sd1, 4'd5, w);
        chk("rstmid_again_wait", 64'(w), 64'd0);
        req_in_flat = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/multicore_in_dispatch.md
# multicore_in_dispatch

Input-side counterpart of the multicore output collector. It serves the per-core input requests (`req_inK`) of the `rede` core array from a single tagged sample stream, and drives the shared `io_in` bus plus a one-hot grant that tells exactly one core when to sample. Arbitration is round-robin among cores whose requested port matches the tag of the pending sample. The block sits between the upstream sample source and the core array, alongside the staggered-reset and output-mux logic.

## Interface

**Parameters**
- `N_CORES`, default 26: number of `rede` cores served.
- `DATA_W`, default 31: signed sample width.
- `REQ_W`, default 4: request/port code width. Code 0 means "no request".
- `GUARD_CYC`, default 2: post-grant cycles during which the served core is masked.

**Ports**
- `clk`, input, 1: single clock, all logic on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `src_data`, input, `DATA_W` signed: upstream sample.
- `src_port`, input, `REQ_W`: port tag of the sample. Values 1..2^REQ_W-1 are valid.
- `src_valid`, input, 1: upstream sample valid.
- `src_ready`, output, 1: dispatcher accepts the sample this cycle.
- `req_in_flat`, input, `N_CORES*REQ_W`: core k's request occupies bits `[k*REQ_W +: REQ_W]`.
- `io_in`, output, `DATA_W` signed: shared input bus to all cores.
- `in_port`, output, `REQ_W`: port tag of the sample on `io_in`.
- `in_grant`, output, `N_CORES`: one-hot; bit k means core k samples `io_in` this cycle.

## Operation

**Match vector.** `match[k] = (req_k != 0) && (req_k == src_port) && !mask[k]`.

**Round-robin pick.** The winner is the first set `match` bit at or after `rr_ptr`, wrapping through `N_CORES-1` back to 0.

**Handshake.**
- `src_ready = (state == IDLE) && src_valid && |match`. It is combinational and never asserted outside IDLE.
- A transfer occurs when `src_valid && src_ready`.
- When `src_valid` is high and there is no match, the source is stalled indefinitely. There is no timeout and no drop.

**FSM states.**
- **IDLE**: `in_grant = 0`. On transfer:
  - latch `src_data` and `src_port`;
  - record the winner;
  - set `rr_ptr` to winner+1, with wrap to 0 at `N_CORES`;
  - go to DRIVE.
- **DRIVE**: exactly 1 cycle. `io_in` and `in_port` show the latched values. `in_grant` is one-hot at the winner. Go to GUARD with the guard counter set to 0.
- **GUARD**: `GUARD_CYC` cycles. `in_grant = 0`. `io_in` and `in_port` hold their values. `mask[winner] = 1` so a stale request is not re-served. When the counter reaches `GUARD_CYC-1`, clear the mask and go to IDLE. If `GUARD_CYC == 0`, go from DRIVE straight to IDLE.

**Output hold.** `io_in` and `in_port` keep their last values in IDLE; they change only when DRIVE is entered.

**Reset.**
- `io_in`, `in_port` and `in_grant` reset to 0; `src_ready` is 0 while `rst` is high.
- `rr_ptr`, the mask and the counter reset to 0; the state resets to IDLE.
- Reset in DRIVE or GUARD discards the latched sample. That sample was already accepted upstream, so it is lost by design. No grant is issued in the cycle after reset.

**Simultaneous events.**
- When several cores match, only the round-robin winner is granted.
- Requests that change in the same cycle as a transfer use the values sampled in that cycle.
- A core dropping its request during DRIVE still receives the grant.

## Timing

- Transfer on edge T. DRIVE (`in_grant`, new `io_in`) in cycle T+1. GUARD in cycles T+2 .. T+1+GUARD_CYC. IDLE in cycle T+2+GUARD_CYC.
- Grant latency from acceptance: 1 cycle.
- Maximum throughput: 1 sample per `GUARD_CYC+2` cycles, i.e. 1 per 4 cycles at the defaults.
- `src_ready` is a combinational function of registered state, `src_valid`, `src_port` and `req_in_flat`. All other outputs are registered.

## Structure

**Shared package `rede_pkg`:**
- `N_CORES`, `DATA_W`, `REQ_W`;
- the `REQ_NONE = 0` constant;
- the dispatcher state enum (IDLE, DRIVE, GUARD).

The multicore collector imports the same constants.

**Sub-module `rr_arbiter`:**
- parameter `N`;
- inputs: `req[N]`, `ptr`;
- outputs: one-hot `grant[N]`, binary `idx`, `any`;
- purely combinational.

The dispatcher owns the FSM, `rr_ptr`, the mask and the data latch.

## Test plan

- **Reset:** after reset, `io_in=0`, `in_port=0`, `in_grant=0`, `src_ready=0` with no requests present.
- **Single request:** core 5 requests code 3; source presents `-7` with tag 3. Required: `src_ready=1` in cycle T; `in_grant=1<<5`, `io_in=-7`, `in_port=3` in T+1; no grant in T+2..T+3; IDLE in T+4.
- **Round robin:** cores 0, 1 and 25 all request code 2 continuously; four samples with tag 2. Required grant order: 0, 1, 25, 0.
- **Tag mismatch:** core 4 requests code 1; source has tag 2 with `src_valid=1`. Required: `src_ready` stays 0 for 50 cycles. Then core 9 requests code 2 → core 9 is granted.
- **Stale request masked:** core 7 holds its request through GUARD with `GUARD_CYC=2` and is the only requester. Required: no second grant before IDLE; the next grant comes 4 cycles after the first.
- **Reset mid-operation:** assert `rst` in the DRIVE cycle. Required: next cycle `in_grant=0`, `io_in=0`, state IDLE, `rr_ptr=0`.
